mult8_seq: RTL

MULT8_SEQ -- requirements
Module: mult8_seq

---
 rtl/mult_defs.sv | 16 +
 rtl/adder8.sv | 27 ++
 rtl/mult8_seq.sv | 99 +++++++++
 3 files changed

// File: rtl/mult_defs.sv
// Shared definitions for the mult8_seq shift-and-add multiplier.
// Holds the FSM state encodings and the iteration count used to size
// and terminate the RUN phase.
package mult_defs;

  // FSM state encodings (2 bits)
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // One RUN cycle per multiplier bit
  localparam int unsigned Iterations = 8;
  localparam int unsigned CntWidth   = $clog2(Iterations);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(Iterations - 1);

endpackage

// File: rtl/adder8.sv
// 8-bit ripple-carry adder used as the single add stage of mult8_seq.
// Ports:
//   x, y  : 8-bit addends
//   cin   : carry in
//   sum   : 8-bit sum
//   cout  : carry out of bit 7
module adder8 (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  always_comb begin
    logic [8:0] c;
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      sum[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1]   = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
    end
    cout = c[8];
  end

endmodule

// File: rtl/mult8_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier.
// A accepted start loads the multiplier into the low half of acc; each of
// eight RUN cycles conditionally adds mcand into the high half and shifts
// right, so after eight cycles acc holds the full 16-bit product.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   start   : request a multiply (accepted in IDLE or DONE)
//   a, b    : multiplicand / multiplier, sampled on accept
//   busy    : high during the eight RUN cycles
//   done    : one-cycle pulse, product valid
//   product : registered result, held until the next DONE
module mult8_seq
  import mult_defs::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     add_sum;
  logic                 add_cout;
  logic [2*WIDTH-1:0]   acc_shift;

  adder8 u_adder8 (
    .x    (acc_q[2*WIDTH-1:WIDTH]),
    .y    (mcand_q),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Carry lands in bit 15 so the partial product can never overflow.
  assign acc_shift = acc_q[0] ? {add_cout, add_sum, acc_q[WIDTH-1:1]}
                              : {1'b0, acc_q[2*WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          mcand_d = a;
          acc_d   = {{WIDTH{1'b0}}, b};
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        acc_d = acc_shift;
        cnt_d = cnt_q + CntWidth'(1);
        if (cnt_q == CntLast) begin
          state_d   = StDone;
          product_d = acc_shift;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == StRun);
  assign done    = (state_q == StDone);
  assign product = product_q;

endmodule
